// File: rtl/mvm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mvm_pkg
// Description : Shared definitions for the streaming matrix-vector unit:
//               FSM state and load-phase encodings, accumulator width helper
//               and the saturate/ReLU output helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mvm_pkg;

    typedef logic [1:0] state_t;

    // Top-level FSM states
    localparam state_t c_ST_LOAD    = 2'd0;
    localparam state_t c_ST_COMPUTE = 2'd1;
    localparam state_t c_ST_OUT     = 2'd2;

    // Sections of an input frame, in arrival order
    localparam logic [1:0] c_PH_M = 2'd0;
    localparam logic [1:0] c_PH_B = 2'd1;
    localparam logic [1:0] c_PH_X = 2'd2;

    // Wide enough for b[i] plus K full-scale products without wrapping.
    function automatic int acc_width(input int dw, input int k);
        return 2 * dw + $clog2(k) + 1;
    endfunction

    // Clamp a sign-extended accumulator to an ow-bit signed range, then
    // optionally clamp negatives to zero. Caller truncates to ow bits.
    function automatic logic signed [63:0] sat_relu(input logic signed [63:0] v,
                                                     input int                 ow,
                                                     input logic               relu);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] r;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        r  = v;
        if (v > hi) begin
            r = hi;
        end else if (v < lo) begin
            r = lo;
        end
        if (relu && (r < 64'sd0)) begin
            r = 64'sd0;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mvm_mac.sv
`default_nettype none
// ============================================================================
// Module      : mvm_mac
// Description : Two-stage pipelined signed MAC. Stage 1 registers a_i*b_i,
//               stage 2 accumulates; first_i reseeds the accumulator with
//               seed_i, last_i marks the final term of a dot product.
// Ports       : clk, reset (async active-low)
//               in_valid_i/first_i/last_i, a_i, b_i, seed_i  - term input
//               out_valid_o, acc_o                             - row result
// Revision    : 1.0 - initial release
// ============================================================================
module mvm_mac
    import mvm_pkg::*;
#(
    parameter int K  = 3,
    parameter int DW = 8
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    in_valid_i,
    input  logic                                    first_i,
    input  logic                                    last_i,
    input  logic signed [DW-1:0]                    a_i,
    input  logic signed [DW-1:0]                    b_i,
    input  logic signed [DW-1:0]                    seed_i,
    output logic                                    out_valid_o,
    output logic signed [acc_width(DW, K)-1:0]      acc_o
);

    localparam int c_ACC_W = acc_width(DW, K);
    localparam int c_PW    = 2 * DW;

    logic signed [c_PW-1:0]    w_prod;
    logic signed [c_PW-1:0]    r_prod_q;
    logic signed [DW-1:0]      r_seed_q;
    logic                      r_p_valid_q;
    logic                      r_p_first_q;
    logic                      r_p_last_q;
    logic signed [c_ACC_W-1:0] r_acc_q;
    logic                      r_out_valid_q;
    logic signed [c_ACC_W-1:0] w_prod_ext;
    logic signed [c_ACC_W-1:0] w_seed_ext;

    assign w_prod     = c_PW'(a_i) * c_PW'(b_i);
    assign w_prod_ext = {{(c_ACC_W - c_PW){r_prod_q[c_PW-1]}}, r_prod_q};
    assign w_seed_ext = {{(c_ACC_W - DW){r_seed_q[DW-1]}}, r_seed_q};

    // Stage 1: product register; seed/flags travel alongside it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prod_q    <= '0;
            r_seed_q    <= '0;
            r_p_valid_q <= 1'b0;
            r_p_first_q <= 1'b0;
            r_p_last_q  <= 1'b0;
        end else begin
            r_p_valid_q <= in_valid_i;
            r_p_first_q <= first_i;
            r_p_last_q  <= last_i;
            if (in_valid_i) begin
                r_prod_q <= w_prod;
                r_seed_q <= seed_i;
            end
        end
    end

    // Stage 2: the first term of a row replaces the running sum with the seed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc_q       <= '0;
            r_out_valid_q <= 1'b0;
        end else begin
            r_out_valid_q <= r_p_valid_q & r_p_last_q;
            if (r_p_valid_q) begin
                r_acc_q <= (r_p_first_q ? w_seed_ext : r_acc_q) + w_prod_ext;
            end
        end
    end

    assign out_valid_o = r_out_valid_q;
    assign acc_o       = r_acc_q;

endmodule
`default_nettype wire

// File: rtl/mvm_param.sv
`default_nettype none
// ============================================================================
// Module      : mvm_param
// Description : Streaming y = M*x + b for a KxK signed matrix. Frames arrive
//               as M (row-major, optional when reusing the stored M), b, x;
//               y[0..K-1] leave saturated to OW bits, optionally ReLU'd.
// Ports       : clk, reset (async active-low)
//               s_valid/s_ready/data_in/reuse_m  - input word stream
//               m_valid/m_ready/data_out         - result stream
// Revision    : 1.0 - initial release
// ============================================================================
module mvm_param
    import mvm_pkg::*;
#(
    parameter int K    = 3,
    parameter int DW   = 8,
    parameter int OW   = 16,
    parameter int RELU = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic                 reuse_m,
    input  logic signed [DW-1:0] data_in,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic signed [OW-1:0] data_out
);

    localparam int c_ACC_W = acc_width(DW, K);
    localparam int c_KK    = K * K;
    localparam int c_MI_W  = $clog2(c_KK);
    localparam int c_KI_W  = $clog2(K);

    localparam logic [c_MI_W-1:0] c_KK_LAST  = c_MI_W'(c_KK - 1);
    localparam logic [c_MI_W-1:0] c_KM_LAST  = c_MI_W'(K - 1);
    localparam logic [c_KI_W-1:0] c_K_LAST   = c_KI_W'(K - 1);

    // Storage (contents survive reset)
    logic signed [DW-1:0] r_m_ram   [c_KK];
    logic signed [DW-1:0] r_b_rf    [K];
    logic signed [DW-1:0] r_x_rf    [K];
    logic signed [OW-1:0] r_res_buf [K];

    state_t               r_state_q;
    state_t               w_state_d;
    logic                 r_s_ready_q;
    logic                 r_m_valid_q;

    // Load bookkeeping
    logic [c_MI_W-1:0]    r_ld_cnt_q;
    logic [1:0]           r_phase_q;
    logic [1:0]           w_phase;
    logic                 r_first_q;
    logic                 r_m_loaded_q;
    logic                 w_hs;
    logic                 w_ld_last_m;
    logic                 w_ld_last_v;
    logic                 w_x_done;

    // Compute bookkeeping
    logic [c_MI_W-1:0]    r_iss_idx_q;
    logic [c_KI_W-1:0]    r_col_q;
    logic [c_KI_W-1:0]    r_row_q;
    logic                 r_iss_done_q;
    logic                 w_iss;
    logic [c_KI_W-1:0]    r_wr_row_q;
    logic                 w_mac_valid;
    logic signed [c_ACC_W-1:0] w_mac_acc;
    logic signed [63:0]   w_acc_ext;
    logic signed [OW-1:0] w_y;

    // Output bookkeeping
    logic [c_KI_W-1:0]    r_out_idx_q;
    logic                 w_out_hs;

    assign w_hs        = s_valid && r_s_ready_q;
    assign w_out_hs    = r_m_valid_q && m_ready;
    // The section of the current word is decided at the first word of a
    // frame: reuse only skips M if a complete M has been stored before.
    assign w_phase     = r_first_q ? ((reuse_m && r_m_loaded_q) ? c_PH_B : c_PH_M)
                                   : r_phase_q;
    assign w_ld_last_m = (r_ld_cnt_q == c_KK_LAST);
    assign w_ld_last_v = (r_ld_cnt_q == c_KM_LAST);
    assign w_x_done    = w_hs && (w_phase == c_PH_X) && w_ld_last_v;
    assign w_iss       = (r_state_q == c_ST_COMPUTE) && !r_iss_done_q;

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            c_ST_LOAD:    if (w_x_done) w_state_d = c_ST_COMPUTE;
            c_ST_COMPUTE: if (w_mac_valid && (r_wr_row_q == c_K_LAST)) w_state_d = c_ST_OUT;
            c_ST_OUT:     if (w_out_hs && (r_out_idx_q == c_K_LAST)) w_state_d = c_ST_LOAD;
            default:      w_state_d = c_ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state_q   <= c_ST_LOAD;
            r_s_ready_q <= 1'b0;
            r_m_valid_q <= 1'b0;
            r_out_idx_q <= '0;
        end else begin
            r_state_q   <= w_state_d;
            // Registered so s_ready stays low while reset is held.
            r_s_ready_q <= (w_state_d == c_ST_LOAD);
            if ((r_state_q == c_ST_COMPUTE) && (w_state_d == c_ST_OUT)) begin
                r_m_valid_q <= 1'b1;
            end else if (w_out_hs && (r_out_idx_q == c_K_LAST)) begin
                r_m_valid_q <= 1'b0;
            end
            if (r_state_q != c_ST_OUT) begin
                r_out_idx_q <= '0;
            end else if (w_out_hs) begin
                r_out_idx_q <= r_out_idx_q + 1'b1;
            end
        end
    end

    // Frame parser
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ld_cnt_q   <= '0;
            r_phase_q    <= c_PH_M;
            r_first_q    <= 1'b1;
            r_m_loaded_q <= 1'b0;
        end else if (w_hs) begin
            r_first_q <= 1'b0;
            r_phase_q <= w_phase;
            case (w_phase)
                c_PH_M: begin
                    if (w_ld_last_m) begin
                        r_ld_cnt_q   <= '0;
                        r_phase_q    <= c_PH_B;
                        r_m_loaded_q <= 1'b1;
                    end else begin
                        r_ld_cnt_q <= r_ld_cnt_q + 1'b1;
                    end
                end
                c_PH_B: begin
                    if (w_ld_last_v) begin
                        r_ld_cnt_q <= '0;
                        r_phase_q  <= c_PH_X;
                    end else begin
                        r_ld_cnt_q <= r_ld_cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (w_ld_last_v) begin
                        r_ld_cnt_q <= '0;
                        r_phase_q  <= c_PH_M;
                        r_first_q  <= 1'b1;
                    end else begin
                        r_ld_cnt_q <= r_ld_cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_hs) begin
            case (w_phase)
                c_PH_M:  r_m_ram[r_ld_cnt_q]             <= data_in;
                c_PH_B:  r_b_rf[r_ld_cnt_q[c_KI_W-1:0]]  <= data_in;
                default: r_x_rf[r_ld_cnt_q[c_KI_W-1:0]]  <= data_in;
            endcase
        end
        if (w_mac_valid) begin
            r_res_buf[r_wr_row_q] <= w_y;
        end
    end

    // Issue one M*x term per cycle, rows back-to-back; counters rest at zero
    // outside COMPUTE so each frame starts clean.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_iss_idx_q  <= '0;
            r_col_q      <= '0;
            r_row_q      <= '0;
            r_iss_done_q <= 1'b0;
            r_wr_row_q   <= '0;
        end else if (r_state_q != c_ST_COMPUTE) begin
            r_iss_idx_q  <= '0;
            r_col_q      <= '0;
            r_row_q      <= '0;
            r_iss_done_q <= 1'b0;
            r_wr_row_q   <= '0;
        end else begin
            if (w_iss) begin
                r_iss_idx_q <= r_iss_idx_q + 1'b1;
                if (r_col_q == c_K_LAST) begin
                    r_col_q <= '0;
                    r_row_q <= r_row_q + 1'b1;
                end else begin
                    r_col_q <= r_col_q + 1'b1;
                end
                if (r_iss_idx_q == c_KK_LAST) begin
                    r_iss_done_q <= 1'b1;
                end
            end
            if (w_mac_valid) begin
                r_wr_row_q <= r_wr_row_q + 1'b1;
            end
        end
    end

    mvm_mac #(
        .K  (K),
        .DW (DW)
    ) u_mac (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (w_iss),
        .first_i     (r_col_q == '0),
        .last_i      (r_col_q == c_K_LAST),
        .a_i         (r_m_ram[r_iss_idx_q]),
        .b_i         (r_x_rf[r_col_q]),
        .seed_i      (r_b_rf[r_row_q]),
        .out_valid_o (w_mac_valid),
        .acc_o       (w_mac_acc)
    );

    assign w_acc_ext = {{(64 - c_ACC_W){w_mac_acc[c_ACC_W-1]}}, w_mac_acc};
    assign w_y       = OW'(sat_relu(w_acc_ext, OW, RELU != 0));

    assign s_ready  = r_s_ready_q;
    assign m_valid  = r_m_valid_q;
    assign data_out = r_m_valid_q ? r_res_buf[r_out_idx_q] : '0;

endmodule
`default_nettype wire

// File: tb/tb_mvm_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_mvm_param
// Description : Scoreboard bench for mvm_param. Two instances (RELU=0 and
//               RELU=1, K=3, DW=8, OW=16) share clock and reset; frames are
//               driven word by word and expected y values are queued from an
//               arithmetic reference model; per-instance monitors pop and
//               compare on every output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mvm_param;

    localparam int K  = 3;
    localparam int KK = K * K;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b1;
    logic              sv   [2];
    logic signed [7:0] din  [2];
    logic              rm   [2];
    logic              sr   [2];
    logic              mv   [2];
    logic              mr   [2];
    logic signed [15:0] dout [2];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int expq0[$];
    int expq1[$];
    int lat_ref [2];
    int oidx    [2];
    int mm      [2][KK];
    bit mld     [2];
    int fm [KK];
    int fb [K];
    int fx [K];
    int bp_mode = 0;
    int hold0   = 0;

    mvm_param #(.K(3), .DW(8), .OW(16), .RELU(0)) u_dut0 (
        .clk(clk), .reset(rst_n), .s_valid(sv[0]), .s_ready(sr[0]), .reuse_m(rm[0]),
        .data_in(din[0]), .m_valid(mv[0]), .m_ready(mr[0]), .data_out(dout[0])
    );

    mvm_param #(.K(3), .DW(8), .OW(16), .RELU(1)) u_dut1 (
        .clk(clk), .reset(rst_n), .s_valid(sv[1]), .s_ready(sr[1]), .reuse_m(rm[1]),
        .data_in(din[1]), .m_valid(mv[1]), .m_ready(mr[1]), .data_out(dout[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sat16(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic int rnd8();
        int s;
        s = int'($urandom_range(0, 9));
        if (s == 0) return 127;
        if (s == 1) return -128;
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    // Reference: y = sat(b + M*x), then ReLU on instance 1.
    task automatic send_frame(input int id, input bit reuse, input bit gaps);
        bit     use_r;
        int     words[$];
        longint acc;
        int     y;
        int     t;
        use_r = reuse && mld[id];
        if (!use_r) begin
            for (int i = 0; i < KK; i++) mm[id][i] = fm[i];
            mld[id] = 1'b1;
        end
        for (int i = 0; i < K; i++) begin
            acc = fb[i];
            for (int j = 0; j < K; j++) acc += longint'(mm[id][i*K+j]) * fx[j];
            y = sat16(acc);
            if (id == 1 && y < 0) y = 0;
            if (id == 0) expq0.push_back(y); else expq1.push_back(y);
        end
        if (!use_r) for (int i = 0; i < KK; i++) words.push_back(fm[i]);
        for (int i = 0; i < K; i++) words.push_back(fb[i]);
        for (int i = 0; i < K; i++) words.push_back(fx[i]);
        for (int w = 0; w < words.size(); w++) begin
            if (gaps) begin
                sv[id] = 1'b0;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            sv[id]  = 1'b1;
            din[id] = 8'(words[w]);
            rm[id]  = (w == 0) ? reuse : 1'($urandom_range(0, 1));
            t = 0;
            forever begin
                @(negedge clk);
                if (sr[id]) break;
                t++;
                if (t > 300) begin
                    errors++; checks++;
                    $display("FAIL s_ready_timeout: got 0 expected 1 (dut %0d word %0d)", id, w);
                    break;
                end
            end
            if (w == words.size() - 1) lat_ref[id] = cyc;
            @(posedge clk); #1;
        end
        sv[id] = 1'b0;
        rm[id] = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_drain(input int id);
        int t;
        t = 0;
        while (((id == 0) ? expq0.size() : expq1.size()) > 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("drain_pending", (id == 0) ? expq0.size() : expq1.size(), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("idle_s_ready", sr[id], 1);
        check("idle_m_valid", mv[id], 0);
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        #1;
        expq0.delete();
        expq1.delete();
        mld[0] = 1'b0; mld[1] = 1'b0;
        lat_ref[0] = -1; lat_ref[1] = -1;
        for (int d = 0; d < 2; d++) begin
            check("rst_s_ready", sr[d], 0);
            check("rst_m_valid", mv[d], 0);
            check("rst_data_out", dout[d], 0);
        end
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_s_ready0", sr[0], 1);
        check("post_rst_s_ready1", sr[1], 1);
        check("post_rst_m_valid0", mv[0], 0);
    endtask

    task automatic monitor(input int id);
        bit pmv;
        bit pmr;
        int pd;
        int e;
        pmv = 1'b0; pmr = 1'b0; pd = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pmv = 1'b0; pmr = 1'b0; oidx[id] = 0;
                continue;
            end
            if (mv[id] && !pmv && lat_ref[id] >= 0) begin
                check("latency", cyc - lat_ref[id], KK + 3);
                lat_ref[id] = -1;
            end
            if (pmv && !pmr) begin
                check("stall_m_valid", mv[id], 1);
                check("stall_data_out", dout[id], pd);
            end
            if (mv[id] && mr[id]) begin
                if (((id == 0) ? expq0.size() : expq1.size()) == 0) begin
                    errors++; checks++;
                    $display("FAIL unexpected_output: got %0d expected none (dut %0d)", dout[id], id);
                end else begin
                    e = (id == 0) ? expq0.pop_front() : expq1.pop_front();
                    check((id == 0) ? "y_relu0" : "y_relu1", dout[id], e);
                end
                oidx[id] = (oidx[id] + 1) % K;
            end
            pmv = mv[id]; pmr = mr[id]; pd = dout[id];
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    // m_ready: always high, random, or a 5-cycle stall on y[1] of instance 0.
    initial begin
        mr[0] = 1'b1; mr[1] = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (bp_mode == 0) begin
                mr[0] = 1'b1;
            end else if (bp_mode == 1) begin
                mr[0] = ($urandom_range(0, 3) != 0);
            end else if (mv[0] && oidx[0] == 1 && hold0 < 5) begin
                mr[0] = 1'b0;
                hold0++;
            end else begin
                mr[0] = 1'b1;
            end
            mr[1] = (bp_mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            sv[d] = 1'b0; din[d] = '0; rm[d] = 1'b0; lat_ref[d] = -1; oidx[d] = 0; mld[d] = 1'b0;
        end
        #2;
        assert_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold_s_ready", sr[0], 0);
        release_reset();

        // Basic: M=1..9, b=1, x=1
        for (int i = 0; i < KK; i++) fm[i] = i + 1;
        for (int i = 0; i < K; i++) begin fb[i] = 1; fx[i] = 1; end
        send_frame(0, 1'b0, 1'b0);
        check("busy_s_ready", sr[0], 0);
        wait_drain(0);

        // Reuse stored M: b=0, x=[1,0,0]
        for (int i = 0; i < K; i++) begin fb[i] = 0; fx[i] = (i == 0) ? 1 : 0; end
        send_frame(0, 1'b1, 1'b0);
        wait_drain(0);

        // reuse_m right after reset must still consume a full frame
        assert_reset();
        repeat (2) @(posedge clk);
        #1;
        release_reset();
        for (int i = 0; i < KK; i++) fm[i] = 2 * (KK - i);
        for (int i = 0; i < K; i++) begin fb[i] = i - 1; fx[i] = i + 2; end
        send_frame(0, 1'b1, 1'b0);
        wait_drain(0);

        // Saturation, positive then negative
        for (int i = 0; i < KK; i++) fm[i] = 127;
        for (int i = 0; i < K; i++) begin fb[i] = 127; fx[i] = 127; end
        send_frame(0, 1'b0, 1'b0);
        wait_drain(0);
        for (int i = 0; i < KK; i++) fm[i] = -128;
        for (int i = 0; i < K; i++) begin fb[i] = -128; fx[i] = 127; end
        send_frame(0, 1'b0, 1'b0);
        wait_drain(0);

        // ReLU vs plain: M=-1, b=0, x=[1,2,3]
        for (int i = 0; i < KK; i++) fm[i] = -1;
        for (int i = 0; i < K; i++) begin fb[i] = 0; fx[i] = i + 1; end
        send_frame(1, 1'b0, 1'b0);
        wait_drain(1);
        send_frame(0, 1'b0, 1'b0);
        wait_drain(0);

        // Backpressure on y[1] plus input gaps
        bp_mode = 2; hold0 = 0;
        for (int i = 0; i < KK; i++) fm[i] = rnd8();
        for (int i = 0; i < K; i++) begin fb[i] = rnd8(); fx[i] = rnd8(); end
        send_frame(0, 1'b0, 1'b1);
        wait_drain(0);

        // Randomised frames on both instances
        bp_mode = 1;
        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < KK; i++) fm[i] = rnd8();
            for (int i = 0; i < K; i++) begin fb[i] = rnd8(); fx[i] = rnd8(); end
            send_frame(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        wait_drain(0);
        wait_drain(1);
        bp_mode = 0;

        // Reset in the middle of COMPUTE
        for (int i = 0; i < KK; i++) fm[i] = rnd8();
        for (int i = 0; i < K; i++) begin fb[i] = rnd8(); fx[i] = rnd8(); end
        send_frame(0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        assert_reset();
        repeat (2) @(posedge clk);
        #1;
        release_reset();
        for (int i = 0; i < KK; i++) fm[i] = rnd8();
        for (int i = 0; i < K; i++) begin fb[i] = rnd8(); fx[i] = rnd8(); end
        send_frame(0, 1'b1, 1'b0);
        wait_drain(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
